resize_shift_ctrl: RTL and testbench
====================================

# resize_shift_ctrl

Runtime shift controller for a parallel resize/cast stage. Counts overflow warnings from the datapath over fixed windows of valid samples and steps a signed shift value with hysteresis: down on heavy overflow, up after consecutive clean windows. New shift values commit only on `sync_in`, so gain changes stay frame-aligned. A settle period after each commit keeps datapath-latency artefacts out of the next measurement. Sits beside the resize stage; `shift_out` drives its runtime shift input and its `warning` feeds `warning_in`.

## Interface
- SHIFT_WIDTH, 4: width of signed shift value (negative = >>, positive = <<)
- SHIFT_MIN, -4: lowest allowed shift
- SHIFT_MAX, 3: highest allowed shift
- SHIFT_INIT, 0: shift after reset
- WINDOW_LOG, 10: window length = 2^WINDOW_LOG valid samples
- OVF_THRESH, 4: overflows per window that force a decrement (≥1)
- CLEAN_WINDOWS, 8: consecutive zero-overflow windows that force an increment (≥1)
- SETTLE_CYCLES, 8: clk cycles ignored after a commit (0 allowed)
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  automatic control on; low forces IDLE
- din_valid  in  1  datapath sample valid
- warning_in  in  1  datapath overflow flag, qualified by din_valid
- sync_in  in  1  frame sync pulse; commit point
- manual_load  in  1  one-cycle request to load manual_shift
- manual_shift  in  SHIFT_WIDTH  signed manual value, clamped to [SHIFT_MIN, SHIFT_MAX]
- shift_out  out  SHIFT_WIDTH  signed active shift, registered
- shift_update  out  1  one-cycle pulse, high in the first cycle the new shift_out is visible
- ovf_count_last  out  WINDOW_LOG+1  overflow count of last completed window
- state_out  out  2  IDLE=0, MEASURE=1, PENDING=2, SETTLE=3

## Operation
- Reset values: shift_out=SHIFT_INIT, shift_update=0, ovf_count_last=0, state=IDLE. All internal counters are 0 and pending is cleared.
- IDLE: counters are held at 0. With enable=1 the FSM moves to MEASURE on the next cycle.
- MEASURE:
  - win_cnt increments on each din_valid.
  - ovf_cnt increments on din_valid&warning_in and saturates at 2^(WINDOW_LOG+1)-1.
- Window end is the cycle with din_valid while win_cnt = 2^WINDOW_LOG-1. The overflow of that same cycle counts, so the decision uses ovf = ovf_cnt + (warning_in ? 1 : 0). At window end:
  - ovf_count_last ← ovf; win_cnt and ovf_cnt ← 0.
  - If ovf ≥ OVF_THRESH: clean_cnt ← 0. If shift_out > SHIFT_MIN: pending ← shift_out-1, go to PENDING. Otherwise stay in MEASURE.
  - Else if ovf = 0: clean_cnt+1. If that reaches CLEAN_WINDOWS: clean_cnt ← 0. If shift_out < SHIFT_MAX: pending ← shift_out+1, go to PENDING. Otherwise stay in MEASURE.
  - Else: clean_cnt ← 0, stay in MEASURE.
- PENDING: waits for sync_in.
  - On sync_in: shift_out ← pending and shift_update=1 at the next edge.
  - Next state is SETTLE if enable=1, otherwise IDLE.
  - A sync_in in the same cycle as the window-end decision does not commit; the next sync_in is required.
- SETTLE: counts SETTLE_CYCLES clk cycles, ignoring din_valid and warning_in, then goes to MEASURE with win_cnt and ovf_cnt at 0. With SETTLE_CYCLES=0, PENDING goes straight to MEASURE.
- manual_load, accepted in any state:
  - pending ← clamp(manual_shift); clean_cnt, win_cnt and ovf_cnt ← 0; go to PENDING.
  - It overrides an automatic decision in the same cycle.
  - It commits on sync_in even when enable=0.
- enable falling:
  - From MEASURE or SETTLE: IDLE next cycle, with counters and clean_cnt cleared. shift_out and ovf_count_last are held.
  - In PENDING: the commit still completes, then the FSM goes to IDLE.
- Commit arithmetic is signed. Results never leave [SHIFT_MIN, SHIFT_MAX].

## Timing
- Decision latency: state_out=PENDING in the cycle after window end.
- Commit latency: shift_out changes 1 cycle after the sync_in it commits on. shift_update is high in that same cycle only.
- shift_out changes only on a commit or on reset.
- rst asserted mid-operation returns every output to its reset value immediately (asynchronous). A pending value is discarded.

## Test plan
All cases use WINDOW_LOG=4, OVF_THRESH=2, CLEAN_WINDOWS=3, SETTLE_CYCLES=5, range -4..3, SHIFT_INIT=0.
- Reset/idle: enable=0, random valid/warning → shift_out=0, state_out=0, shift_update never high.
- Decrement: 16 valids with 2 warnings, sync_in 10 cycles later → ovf_count_last=2, PENDING, shift_out=-1 one cycle after sync_in with a 1-cycle shift_update. No window counting for 5 cycles after the commit.
- Increment with hysteresis: 3 clean windows → shift_out 0→1. Then 2 clean windows, 1 window with 1 warning, 2 clean windows → no change (clean_cnt reset).
- Saturation: from -4, a window with 16 warnings → no PENDING, no update, ovf_count_last=16. From 3, 3 clean windows → no change.
- Boundary: 2nd warning on the final valid of a window → decrement. sync_in in the decision cycle → ignored; the commit happens on the following sync.
- Manual/async: manual_load with manual_shift=7 during MEASURE → commit to 3 on next sync. rst mid-PENDING → shift_out=0, state_out=0, and no commit on the later sync.

Source files
------------

// File: rtl/resize_shift_ctrl.sv
// resize_shift_ctrl
//   Runtime shift controller for a parallel resize/cast stage. Counts the
//   datapath overflow warnings over windows of 2^WINDOW_LOG valid samples and
//   steps a signed shift value with hysteresis: it steps down after a window
//   with at least OVF_THRESH overflows, and up after CLEAN_WINDOWS consecutive
//   windows with no overflow. A new shift value only takes effect on sync_in,
//   so gain changes stay aligned to frames. After each commit, SETTLE_CYCLES
//   clock cycles are skipped before the next window is measured.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   enable            automatic control on; low returns to IDLE
//   din_valid         datapath sample valid
//   warning_in        datapath overflow flag, qualified by din_valid
//   sync_in           frame sync pulse, commit point for a pending shift
//   manual_load       one-cycle request to load manual_shift (clamped)
//   manual_shift      signed manual shift value
//   shift_out         signed active shift (registered)
//   shift_update      one-cycle pulse in the first cycle a new shift_out shows
//   ovf_count_last    overflow count of the last completed window
//   state_out         IDLE=0, MEASURE=1, PENDING=2, SETTLE=3
module resize_shift_ctrl #(
    parameter int SHIFT_WIDTH   = 4,
    parameter int SHIFT_MIN     = -4,
    parameter int SHIFT_MAX     = 3,
    parameter int SHIFT_INIT    = 0,
    parameter int WINDOW_LOG    = 10,
    parameter int OVF_THRESH    = 4,
    parameter int CLEAN_WINDOWS = 8,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          din_valid,
    input  logic                          warning_in,
    input  logic                          sync_in,
    input  logic                          manual_load,
    input  logic signed [SHIFT_WIDTH-1:0] manual_shift,
    output logic signed [SHIFT_WIDTH-1:0] shift_out,
    output logic                          shift_update,
    output logic [WINDOW_LOG:0]           ovf_count_last,
    output logic [1:0]                    state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        PENDING = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int CW = $clog2(CLEAN_WINDOWS + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic signed [SHIFT_WIDTH-1:0] S_MIN  = SHIFT_WIDTH'(SHIFT_MIN);
    localparam logic signed [SHIFT_WIDTH-1:0] S_MAX  = SHIFT_WIDTH'(SHIFT_MAX);
    localparam logic signed [SHIFT_WIDTH-1:0] S_INIT = SHIFT_WIDTH'(SHIFT_INIT);
    localparam logic signed [SHIFT_WIDTH-1:0] S_ONE  = SHIFT_WIDTH'(1);

    localparam logic [WINDOW_LOG-1:0] WIN_LAST = {WINDOW_LOG{1'b1}};
    localparam logic [WINDOW_LOG-1:0] WIN_ONE  = WINDOW_LOG'(1);
    localparam logic [WINDOW_LOG:0]   OVF_MAX  = {(WINDOW_LOG+1){1'b1}};
    localparam logic [WINDOW_LOG:0]   OVF_ONE  = (WINDOW_LOG+1)'(1);
    localparam logic [WINDOW_LOG:0]   OVF_THR  = (WINDOW_LOG+1)'(OVF_THRESH);
    localparam logic [CW-1:0]         CLEAN_ONE = CW'(1);
    localparam logic [CW-1:0]         CLEAN_TGT = CW'(CLEAN_WINDOWS);
    localparam logic [SW-1:0]         SET_ONE   = SW'(1);
    localparam logic [SW-1:0]         SET_LAST  = SW'(SETTLE_CYCLES - 1);

    // With no settle period a commit goes straight back to measuring.
    localparam state_t POST_COMMIT = (SETTLE_CYCLES == 0) ? MEASURE : SETTLE;

    state_t                         state;
    logic signed [SHIFT_WIDTH-1:0]  pending;
    logic [WINDOW_LOG-1:0]          win_cnt;
    logic [WINDOW_LOG:0]            ovf_cnt;
    logic [CW-1:0]                  clean_cnt;
    logic [SW-1:0]                  settle_cnt;

    logic [WINDOW_LOG:0]            ovf;
    logic [CW-1:0]                  clean_next;
    logic signed [SHIFT_WIDTH-1:0]  manual_clamped;
    logic signed [SHIFT_WIDTH-1:0]  shift_dec;
    logic signed [SHIFT_WIDTH-1:0]  shift_inc;

    assign state_out = state;

    // Overflow count including this cycle's warning, saturating.
    always_comb begin
        ovf = ovf_cnt;
        if (warning_in && (ovf_cnt != OVF_MAX)) begin
            ovf = ovf_cnt + OVF_ONE;
        end
    end

    always_comb begin
        manual_clamped = manual_shift;
        if (manual_shift < S_MIN) begin
            manual_clamped = S_MIN;
        end else if (manual_shift > S_MAX) begin
            manual_clamped = S_MAX;
        end
    end

    assign clean_next = clean_cnt + CLEAN_ONE;
    // Only used when shift_out is strictly inside the range, so never wraps.
    assign shift_dec  = shift_out - S_ONE;
    assign shift_inc  = shift_out + S_ONE;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shift_out      <= S_INIT;
            shift_update   <= 1'b0;
            ovf_count_last <= '0;
            pending        <= S_INIT;
            win_cnt        <= '0;
            ovf_cnt        <= '0;
            clean_cnt      <= '0;
            settle_cnt     <= '0;
        end else begin
            shift_update <= 1'b0;

            if (manual_load) begin
                // A manual request wins over any automatic decision this cycle.
                pending    <= manual_clamped;
                win_cnt    <= '0;
                ovf_cnt    <= '0;
                clean_cnt  <= '0;
                settle_cnt <= '0;
                state      <= PENDING;
            end else begin
                case (state)
                    IDLE: begin
                        win_cnt    <= '0;
                        ovf_cnt    <= '0;
                        clean_cnt  <= '0;
                        settle_cnt <= '0;
                        if (enable) begin
                            state <= MEASURE;
                        end
                    end

                    MEASURE: begin
                        if (!enable) begin
                            win_cnt   <= '0;
                            ovf_cnt   <= '0;
                            clean_cnt <= '0;
                            state     <= IDLE;
                        end else if (din_valid) begin
                            if (win_cnt == WIN_LAST) begin
                                ovf_count_last <= ovf;
                                win_cnt        <= '0;
                                ovf_cnt        <= '0;
                                if (ovf >= OVF_THR) begin
                                    clean_cnt <= '0;
                                    if (shift_out > S_MIN) begin
                                        pending <= shift_dec;
                                        state   <= PENDING;
                                    end
                                end else if (ovf == '0) begin
                                    if (clean_next == CLEAN_TGT) begin
                                        clean_cnt <= '0;
                                        if (shift_out < S_MAX) begin
                                            pending <= shift_inc;
                                            state   <= PENDING;
                                        end
                                    end else begin
                                        clean_cnt <= clean_next;
                                    end
                                end else begin
                                    clean_cnt <= '0;
                                end
                            end else begin
                                win_cnt <= win_cnt + WIN_ONE;
                                ovf_cnt <= ovf;
                            end
                        end
                    end

                    PENDING: begin
                        // A started commit completes even if enable dropped.
                        if (sync_in) begin
                            shift_out    <= pending;
                            shift_update <= 1'b1;
                            settle_cnt   <= '0;
                            win_cnt      <= '0;
                            ovf_cnt      <= '0;
                            state        <= enable ? POST_COMMIT : IDLE;
                        end
                    end

                    SETTLE: begin
                        if (!enable) begin
                            win_cnt    <= '0;
                            ovf_cnt    <= '0;
                            clean_cnt  <= '0;
                            settle_cnt <= '0;
                            state      <= IDLE;
                        end else if (settle_cnt == SET_LAST) begin
                            settle_cnt <= '0;
                            win_cnt    <= '0;
                            ovf_cnt    <= '0;
                            state      <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + SET_ONE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_resize_shift_ctrl.sv
// tb_resize_shift_ctrl
//   Directed bench for resize_shift_ctrl with a 16-sample window, overflow
//   threshold 2, three clean windows for a step up, five settle cycles and a
//   shift range of -4..3. Inputs change 1 time unit after the rising edge and
//   outputs are sampled at the same point, so each tick() shows the result of
//   exactly one clock edge.
module tb_resize_shift_ctrl;

    localparam int SW = 4;
    localparam int WL = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 din_valid;
    logic                 warning_in;
    logic                 sync_in;
    logic                 manual_load;
    logic signed [SW-1:0] manual_shift;
    logic signed [SW-1:0] shift_out;
    logic                 shift_update;
    logic [WL:0]          ovf_count_last;
    logic [1:0]           state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resize_shift_ctrl #(
        .SHIFT_WIDTH  (SW),
        .SHIFT_MIN    (-4),
        .SHIFT_MAX    (3),
        .SHIFT_INIT   (0),
        .WINDOW_LOG   (WL),
        .OVF_THRESH   (2),
        .CLEAN_WINDOWS(3),
        .SETTLE_CYCLES(5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .din_valid     (din_valid),
        .warning_in    (warning_in),
        .sync_in       (sync_in),
        .manual_load   (manual_load),
        .manual_shift  (manual_shift),
        .shift_out     (shift_out),
        .shift_update  (shift_update),
        .ovf_count_last(ovf_count_last),
        .state_out     (state_out)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full window of 16 valid samples; warning_in follows mask bit i.
    // With sync_last set, sync_in is raised together with the final sample.
    task automatic send_window(input logic [15:0] mask, input bit sync_last);
        for (int i = 0; i < 16; i++) begin
            din_valid  = 1'b1;
            warning_in = mask[i];
            sync_in    = sync_last && (i == 15);
            tick();
        end
        din_valid  = 1'b0;
        warning_in = 1'b0;
        sync_in    = 1'b0;
    endtask

    task automatic commit();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    task automatic manual(input logic signed [SW-1:0] value);
        manual_shift = value;
        manual_load  = 1'b1;
        tick();
        manual_load  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int upd_seen;
        int busy_seen;

        rst          = 1'b1;
        enable       = 1'b0;
        din_valid    = 1'b0;
        warning_in   = 1'b0;
        sync_in      = 1'b0;
        manual_load  = 1'b0;
        manual_shift = '0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_shift", shift_out, 0);
        check("rst_update", shift_update, 0);
        check("rst_ovf_last", ovf_count_last, 0);
        check("rst_state", state_out, 0);
        rst = 1'b0;

        // ---------------- idle with random traffic ----------------
        upd_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            din_valid  = 1'($urandom_range(1));
            warning_in = 1'($urandom_range(1));
            sync_in    = 1'($urandom_range(1));
            tick();
            if (shift_update) upd_seen++;
            if (state_out != 2'd0 || shift_out != 0) busy_seen++;
        end
        din_valid  = 1'b0;
        warning_in = 1'b0;
        sync_in    = 1'b0;
        check("idle_update_pulses", upd_seen, 0);
        check("idle_not_idle_cycles", busy_seen, 0);
        check("idle_ovf_last", ovf_count_last, 0);

        // ---------------- decrement ----------------
        enable = 1'b1;
        tick();
        check("en_state_measure", state_out, 1);
        send_window(16'h0420, 1'b0);
        check("dec_ovf_last", ovf_count_last, 2);
        check("dec_state_pending", state_out, 2);
        check("dec_shift_held", shift_out, 0);
        repeat (9) tick();
        check("dec_wait_state", state_out, 2);
        check("dec_wait_shift", shift_out, 0);
        commit();
        check("dec_shift", shift_out, -1);
        check("dec_update_hi", shift_update, 1);
        check("dec_state_settle", state_out, 3);
        // Valid samples with warnings during settle must not be counted.
        for (int k = 1; k <= 5; k++) begin
            din_valid  = 1'b1;
            warning_in = 1'b1;
            tick();
            if (k == 1) check("dec_update_lo", shift_update, 0);
            if (k < 5) check("settle_state", state_out, 3);
        end
        check("settle_done_state", state_out, 1);
        warning_in = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("win15_state", state_out, 1);
        check("win15_ovf_last", ovf_count_last, 2);
        tick();
        din_valid = 1'b0;
        check("win16_ovf_last", ovf_count_last, 0);
        check("win16_state", state_out, 1);

        // ---------------- increment with hysteresis ----------------
        // One clean window already counted; two more step -1 -> 0.
        send_window(16'h0000, 1'b0);
        check("inc_a_no_pending", state_out, 1);
        send_window(16'h0000, 1'b0);
        check("inc_a_pending", state_out, 2);
        commit();
        check("inc_a_shift", shift_out, 0);
        check("inc_a_update", shift_update, 1);
        repeat (5) tick();
        check("inc_a_measure", state_out, 1);
        for (int w = 0; w < 3; w++) send_window(16'h0000, 1'b0);
        check("inc_b_pending", state_out, 2);
        commit();
        check("inc_b_shift", shift_out, 1);
        repeat (5) tick();
        send_window(16'h0000, 1'b0);
        send_window(16'h0000, 1'b0);
        send_window(16'h0100, 1'b0);
        check("hyst_ovf_last", ovf_count_last, 1);
        send_window(16'h0000, 1'b0);
        send_window(16'h0000, 1'b0);
        check("hyst_state", state_out, 1);
        check("hyst_shift", shift_out, 1);
        send_window(16'h0000, 1'b0);
        check("hyst_third_pending", state_out, 2);
        commit();
        check("hyst_shift_up", shift_out, 2);
        repeat (5) tick();

        // ---------------- saturation ----------------
        manual(-4'sd4);
        check("man_min_pending", state_out, 2);
        commit();
        check("man_min_shift", shift_out, -4);
        repeat (5) tick();
        send_window(16'hFFFF, 1'b0);
        check("sat_lo_ovf_last", ovf_count_last, 16);
        check("sat_lo_state", state_out, 1);
        check("sat_lo_shift", shift_out, -4);
        check("sat_lo_update", shift_update, 0);

        // ---------------- manual load clamps ----------------
        manual(4'sd7);
        check("man_clamp_pending", state_out, 2);
        check("man_clamp_held", shift_out, -4);
        commit();
        check("man_clamp_shift", shift_out, 3);
        check("man_clamp_update", shift_update, 1);
        repeat (5) tick();
        upd_seen = 0;
        for (int w = 0; w < 3; w++) begin
            send_window(16'h0000, 1'b0);
            if (state_out != 2'd1) upd_seen++;
        end
        check("sat_hi_left_measure", upd_seen, 0);
        check("sat_hi_shift", shift_out, 3);

        // ---------------- boundary ----------------
        send_window(16'h8008, 1'b1);
        check("bnd_ovf_last", ovf_count_last, 2);
        check("bnd_state_pending", state_out, 2);
        check("bnd_sync_ignored_shift", shift_out, 3);
        check("bnd_sync_ignored_update", shift_update, 0);
        tick();
        check("bnd_still_pending", state_out, 2);
        commit();
        check("bnd_shift", shift_out, 2);
        check("bnd_update", shift_update, 1);
        repeat (5) tick();
        check("bnd_measure", state_out, 1);

        // ---------------- async reset mid-PENDING ----------------
        manual(-4'sd3);
        check("rstp_pending", state_out, 2);
        enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rstp_shift", shift_out, 0);
        check("rstp_state", state_out, 0);
        check("rstp_ovf_last", ovf_count_last, 0);
        tick();
        rst = 1'b0;
        commit();
        check("rstp_no_commit_shift", shift_out, 0);
        check("rstp_no_commit_update", shift_update, 0);
        check("rstp_no_commit_state", state_out, 0);

        // ---------------- manual commit with enable low ----------------
        manual(-4'sd2);
        check("man_dis_pending", state_out, 2);
        commit();
        check("man_dis_shift", shift_out, -2);
        check("man_dis_update", shift_update, 1);
        check("man_dis_state_idle", state_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
